// File: rtl/mem_lsu.sv
// mem_lsu: registered req/ack load/store master for the MEM stage. A zero-wait single beat stalls 2 cycles, plus 1 per wait state.
// The pipeline stalls while a beat is pending and TIMEOUT_CYC bounds each beat; define MISALIGN_SPLIT_EN for two-beat misaligned accesses.
module mem_lsu #(
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i,
   input  logic [7:0]        aluop_i,
   input  logic [4:0]        wd_i,
   input  logic              wreg_i,
   input  logic [31:0]       wdata_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [31:0]       reg2_i,
   output logic [4:0]        wd_o,
   output logic              wreg_o,
   output logic [31:0]       wdata_o,
   output logic              stall_req_o,
   output logic              err_o,
   output logic              bus_req_o,
   output logic              bus_we_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic [3:0]        bus_sel_o,
   output logic [31:0]       bus_wdata_o,
   input  logic              bus_ack_i,
   input  logic [31:0]       bus_rdata_i
);
   localparam logic [7:0] EXE_LB  = 8'b1110_0000;
   localparam logic [7:0] EXE_LH  = 8'b1110_0001;
   localparam logic [7:0] EXE_LW  = 8'b1110_0011;
   localparam logic [7:0] EXE_LBU = 8'b1110_0100;
   localparam logic [7:0] EXE_LHU = 8'b1110_0101;
   localparam logic [7:0] EXE_SB  = 8'b1110_1000;
   localparam logic [7:0] EXE_SH  = 8'b1110_1001;
   localparam logic [7:0] EXE_SW  = 8'b1110_1011;
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, DONE, ERR} state_t;

   function automatic logic op_is_mem(input logic [7:0] op);
      case (op)
         EXE_LB, EXE_LH, EXE_LW, EXE_LBU, EXE_LHU, EXE_SB, EXE_SH, EXE_SW: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic op_is_store(input logic [7:0] op);
      return (op == EXE_SB) || (op == EXE_SH) || (op == EXE_SW);
   endfunction

   function automatic logic op_is_signed(input logic [7:0] op);
      return (op == EXE_LB) || (op == EXE_LH);
   endfunction

   // 0 = byte, 1 = half, 2 = word
   function automatic logic [1:0] op_size(input logic [7:0] op);
      case (op)
         EXE_LB, EXE_LBU, EXE_SB: return 2'd0;
         EXE_LH, EXE_LHU, EXE_SH: return 2'd1;
         default:                 return 2'd2;
      endcase
   endfunction

   function automatic logic [3:0] size_mask(input logic [1:0] sz);
      case (sz)
         2'd0:    return 4'b0001;
         2'd1:    return 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] fmt_wdata(input logic [1:0] sz, input logic [1:0] k, input logic [31:0] d);
      logic [4:0] sh;
      sh = {k, 3'b000};
      case (sz)
         2'd0:    return {4{d[7:0]}};
         2'd1:    return {2{d[15:0]}};
         default: return (d << sh) | (d >> (6'd32 - {1'b0, sh}));
      endcase
   endfunction

   state_t      state;
   logic [15:0] cnt;
   logic [7:0]  op_q;
   logic [1:0]  k_q;
   logic [4:0]  wd_q;
   logic        wreg_q;
   logic [31:0] beat0_q;
   logic [31:0] beat1_v;
   logic [31:0] raw;
   logic [31:0] load_res;

   logic       in_mem, in_split, go_err;
   logic [1:0] in_k, in_size;
   logic [3:0] in_sel;

   assign in_mem   = valid_i && op_is_mem(aluop_i);
   assign in_k     = mem_addr_i[1:0];
   assign in_size  = op_size(aluop_i);
   assign in_split = ((in_size == 2'd2) && (in_k != 2'd0)) || ((in_size == 2'd1) && (in_k == 2'd3));
   assign in_sel   = 4'({4'b0000, size_mask(in_size)} << in_k);

`ifdef MISALIGN_SPLIT_EN
   logic [31:0] beat1_q;
   logic        split_q;
   logic [3:0]  sel1;
   assign go_err  = 1'b0;
   assign beat1_v = beat1_q;
   assign sel1    = size_mask(op_size(op_q)) >> (3'd4 - {1'b0, k_q});
`else
   assign go_err  = in_split;
   assign beat1_v = 32'h0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         cnt         <= '0;
         op_q        <= '0;
         k_q         <= '0;
         wd_q        <= '0;
         wreg_q      <= 1'b0;
         beat0_q     <= '0;
         err_o       <= 1'b0;
         bus_req_o   <= 1'b0;
         bus_we_o    <= 1'b0;
         bus_addr_o  <= '0;
         bus_sel_o   <= '0;
         bus_wdata_o <= '0;
`ifdef MISALIGN_SPLIT_EN
         beat1_q     <= '0;
         split_q     <= 1'b0;
`endif
      end else begin
         err_o <= 1'b0;
         case (state)
            IDLE: if (in_mem) begin
               op_q   <= aluop_i;
               k_q    <= in_k;
               wd_q   <= wd_i;
               wreg_q <= wreg_i;
               cnt    <= '0;
`ifdef MISALIGN_SPLIT_EN
               split_q <= in_split;
`endif
               if (go_err) begin
                  state <= ERR;
                  err_o <= 1'b1;
               end else begin
                  state       <= BEAT0;
                  bus_req_o   <= 1'b1;
                  bus_we_o    <= op_is_store(aluop_i);
                  bus_addr_o  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
                  bus_sel_o   <= in_sel;
                  bus_wdata_o <= fmt_wdata(in_size, in_k, reg2_i);
               end
            end
            BEAT0: if (bus_req_o && bus_ack_i) begin
               beat0_q <= bus_rdata_i;
               cnt     <= '0;
`ifdef MISALIGN_SPLIT_EN
               if (split_q) begin
                  state      <= BEAT1;
                  bus_addr_o <= bus_addr_o + ADDR_W'(4);
                  bus_sel_o  <= sel1;
               end else begin
                  state     <= DONE;
                  bus_req_o <= 1'b0;
               end
`else
               state     <= DONE;
               bus_req_o <= 1'b0;
`endif
            end else if (cnt == TO_LAST) begin
               state     <= ERR;
               err_o     <= 1'b1;
               bus_req_o <= 1'b0;
            end else begin
               cnt <= cnt + 16'd1;
            end
`ifdef MISALIGN_SPLIT_EN
            BEAT1: if (bus_req_o && bus_ack_i) begin
               beat1_q   <= bus_rdata_i;
               state     <= DONE;
               bus_req_o <= 1'b0;
            end else if (cnt == TO_LAST) begin
               state     <= ERR;
               err_o     <= 1'b1;
               bus_req_o <= 1'b0;
            end else begin
               cnt <= cnt + 16'd1;
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

   assign raw = 32'({beat1_v, beat0_q} >> {k_q, 3'b000});

   always_comb begin
      load_res = raw;
      case (op_size(op_q))
         2'd0:    load_res = op_is_signed(op_q) ? {{24{raw[7]}}, raw[7:0]} : {24'h0, raw[7:0]};
         2'd1:    load_res = op_is_signed(op_q) ? {{16{raw[15]}}, raw[15:0]} : {16'h0, raw[15:0]};
         default: load_res = raw;
      endcase
   end

   // Held at zero during reset so an aborted access cannot leak a writeback or stall.
   always_comb begin
      wd_o        = '0;
      wreg_o      = 1'b0;
      wdata_o     = '0;
      stall_req_o = 1'b0;
      if (rst) begin
         case (state)
            IDLE: begin
               wd_o        = wd_i;
               wreg_o      = wreg_i && !in_mem;
               wdata_o     = wdata_i;
               stall_req_o = in_mem;
            end
            BEAT0, BEAT1: stall_req_o = 1'b1;
            DONE: begin
               wd_o    = wd_q;
               wreg_o  = wreg_q;
               wdata_o = op_is_store(op_q) ? wdata_i : load_res;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: table of single-beat accesses, split/abort sequences, timeout and reset abort.
module tb_mem_lsu;
   localparam logic [7:0] OP_LB  = 8'b1110_0000;
   localparam logic [7:0] OP_LH  = 8'b1110_0001;
   localparam logic [7:0] OP_LW  = 8'b1110_0011;
   localparam logic [7:0] OP_LBU = 8'b1110_0100;
   localparam logic [7:0] OP_LHU = 8'b1110_0101;
   localparam logic [7:0] OP_SB  = 8'b1110_1000;
   localparam logic [7:0] OP_SH  = 8'b1110_1001;
   localparam logic [7:0] OP_SW  = 8'b1110_1011;
   localparam logic [7:0] OP_ADD = 8'b0010_0000;
   localparam logic [31:0] REG2  = 32'hA1B2C3D4;
   localparam logic [31:0] WDIN  = 32'h55AA55AA;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i;
   logic [7:0]  aluop_i;
   logic [4:0]  wd_i;
   logic        wreg_i;
   logic [31:0] wdata_i;
   logic [31:0] mem_addr_i;
   logic [31:0] reg2_i;
   logic [4:0]  wd_o;
   logic        wreg_o;
   logic [31:0] wdata_o;
   logic        stall_req_o;
   logic        err_o;
   logic        bus_req_o;
   logic        bus_we_o;
   logic [31:0] bus_addr_o;
   logic [3:0]  bus_sel_o;
   logic [31:0] bus_wdata_o;
   logic        bus_ack_i;
   logic [31:0] bus_rdata_i;

   mem_lsu #(.ADDR_W(32), .TIMEOUT_CYC(4)) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .aluop_i(aluop_i),
      .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
      .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
      .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
      .stall_req_o(stall_req_o), .err_o(err_o),
      .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
      .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
      .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  sel;
      logic [31:0] wdata;
      logic        we;
   } beat_t;

   typedef struct {
      logic [7:0]  op;
      logic [31:0] addr;
      logic [31:0] rd;
      logic [3:0]  sel;
      logic [31:0] baddr;
      logic [31:0] bw;
      logic        we;
      logic [31:0] res;
   } vec_t;

   beat_t       beat_q[$];
   logic [31:0] res_q[$];
   vec_t        vecs[9];
   int          errors = 0;
   int          checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=absent required=present", name);
   endtask

   // Drives one op and acts as the bus slave; expected beats/results come from the queues.
   task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                         input logic wreg, input int waits, input logic [31:0] rd0, input logic [31:0] rd1,
                         input logic exp_err, output int n_stall, output int n_bus);
      int    wcnt;
      int    beat;
      bit    done;
      beat_t b;
      logic [31:0] r;
      wcnt = 0; beat = 0; done = 0; n_stall = 0; n_bus = 0;
      for (int cyc = 0; cyc < 64 && !done; cyc++) begin
         @(negedge clk);
         if (cyc == 0) begin
            valid_i = 1'b1; aluop_i = op; mem_addr_i = addr; reg2_i = reg2;
            wreg_i = wreg; wd_i = 5'd7; wdata_i = WDIN;
         end
         bus_ack_i = 1'b0;
         bus_rdata_i = 32'h0;
         if (bus_req_o) begin
            n_bus++;
            if (wcnt >= waits) begin
               bus_ack_i = 1'b1;
               bus_rdata_i = (beat == 0) ? rd0 : rd1;
            end else begin
               wcnt++;
            end
         end
         #1;
         if (stall_req_o) n_stall++;
         if (bus_req_o && bus_ack_i) begin
            if (beat_q.size() == 0) begin
               fail_now("beat_unexpected");
            end else begin
               b = beat_q.pop_front();
               chk("beat_addr", bus_addr_o, b.addr);
               chk("beat_sel", 32'(bus_sel_o), 32'(b.sel));
               chk("beat_wdata", bus_wdata_o, b.wdata);
               chk("beat_we", 32'(bus_we_o), 32'(b.we));
            end
            beat++;
            wcnt = 0;
         end
         if (cyc > 0 && !stall_req_o) begin
            done = 1;
            chk("err_flag", 32'(err_o), 32'(exp_err));
            if (exp_err) begin
               chk("err_wreg", 32'(wreg_o), 32'h0);
            end else if (res_q.size() == 0) begin
               fail_now("result_expected");
            end else begin
               r = res_q.pop_front();
               chk("result_wdata", wdata_o, r);
               chk("result_wreg", 32'(wreg_o), 32'(wreg));
               chk("result_wd", 32'(wd_o), 32'd7);
            end
         end
      end
      if (!done) fail_now("op_completion");
      chk("beats_left", 32'(beat_q.size()), 32'd0);
      @(negedge clk);
      valid_i = 1'b0; aluop_i = OP_ADD; bus_ack_i = 1'b0;
      #1;
      chk("err_pulse_end", 32'(err_o), 32'h0);
      chk("idle_stall", 32'(stall_req_o), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int ns, nb;
      vecs[0] = '{OP_LW,  32'h100, 32'hDEADBEEF, 4'b1111, 32'h100, 32'hA1B2C3D4, 1'b0, 32'hDEADBEEF};
      vecs[1] = '{OP_LB,  32'h103, 32'h80123456, 4'b1000, 32'h100, 32'hD4D4D4D4, 1'b0, 32'hFFFFFF80};
      vecs[2] = '{OP_LBU, 32'h103, 32'h80123456, 4'b1000, 32'h100, 32'hD4D4D4D4, 1'b0, 32'h00000080};
      vecs[3] = '{OP_LH,  32'h101, 32'h12F0E034, 4'b0110, 32'h100, 32'hC3D4C3D4, 1'b0, 32'hFFFFF0E0};
      vecs[4] = '{OP_LHU, 32'h102, 32'h80012345, 4'b1100, 32'h100, 32'hC3D4C3D4, 1'b0, 32'h00008001};
      vecs[5] = '{OP_SB,  32'h301, 32'h0,        4'b0010, 32'h300, 32'hD4D4D4D4, 1'b1, WDIN};
      vecs[6] = '{OP_SH,  32'h302, 32'h0,        4'b1100, 32'h300, 32'hC3D4C3D4, 1'b1, WDIN};
      vecs[7] = '{OP_SW,  32'h400, 32'h0,        4'b1111, 32'h400, 32'hA1B2C3D4, 1'b1, WDIN};
      vecs[8] = '{OP_LB,  32'h000, 32'h0000007F, 4'b0001, 32'h000, 32'hD4D4D4D4, 1'b0, 32'h0000007F};

      rst = 1'b0; bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
      valid_i = 1'b1; aluop_i = OP_ADD; wd_i = 5'd3; wreg_i = 1'b1;
      wdata_i = 32'h12345678; mem_addr_i = 32'h0; reg2_i = REG2;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_bus_req", 32'(bus_req_o), 32'h0);
      chk("rst_stall", 32'(stall_req_o), 32'h0);
      chk("rst_err", 32'(err_o), 32'h0);
      chk("rst_wreg", 32'(wreg_o), 32'h0);
      chk("rst_wdata", wdata_o, 32'h0);
      chk("rst_sel", 32'(bus_sel_o), 32'h0);

      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("pass_wdata", wdata_o, 32'h12345678);
      chk("pass_wreg", 32'(wreg_o), 32'h1);
      chk("pass_wd", 32'(wd_o), 32'd3);
      chk("pass_stall", 32'(stall_req_o), 32'h0);
      valid_i = 1'b0; aluop_i = OP_LW;
      #1;
      chk("novalid_stall", 32'(stall_req_o), 32'h0);
      chk("novalid_wdata", wdata_o, 32'h12345678);

      // Stray ack while idle must not start anything.
      @(negedge clk); bus_ack_i = 1'b1;
      @(negedge clk); bus_ack_i = 1'b0; aluop_i = OP_ADD;
      #1;
      chk("stray_ack_req", 32'(bus_req_o), 32'h0);
      chk("stray_ack_err", 32'(err_o), 32'h0);

      for (int i = 0; i < 9; i++) begin
         beat_q.push_back('{vecs[i].baddr, vecs[i].sel, vecs[i].bw, vecs[i].we});
         res_q.push_back(vecs[i].res);
         run_op(vecs[i].op, vecs[i].addr, REG2, !vecs[i].we, 0, vecs[i].rd, 32'h0, 1'b0, ns, nb);
         chk("single_stall_cycles", 32'(ns), 32'd2);
         chk("single_bus_cycles", 32'(nb), 32'd1);
      end

`ifdef MISALIGN_SPLIT_EN
      beat_q.push_back('{32'h200, 4'b1110, 32'h22334411, 1'b1});
      beat_q.push_back('{32'h204, 4'b0001, 32'h22334411, 1'b1});
      res_q.push_back(WDIN);
      run_op(OP_SW, 32'h201, 32'h11223344, 1'b0, 1, 32'h0, 32'h0, 1'b0, ns, nb);
      chk("split_sw_bus_cycles", 32'(nb), 32'd4);
      chk("split_sw_stall", 32'(ns), 32'd5);

      beat_q.push_back('{32'h1FC, 4'b1000, 32'hC3D4C3D4, 1'b0});
      beat_q.push_back('{32'h200, 4'b0001, 32'hC3D4C3D4, 1'b0});
      res_q.push_back(32'hFFFFCDAB);
      run_op(OP_LH, 32'h1FF, REG2, 1'b1, 0, 32'hAB000000, 32'h000000CD, 1'b0, ns, nb);
      chk("split_lh_bus_cycles", 32'(nb), 32'd2);

      beat_q.push_back('{32'hFFFFFFFC, 4'b1100, 32'hC3D4A1B2, 1'b0});
      beat_q.push_back('{32'h00000000, 4'b0011, 32'hC3D4A1B2, 1'b0});
      res_q.push_back(32'h44332211);
      run_op(OP_LW, 32'hFFFFFFFE, REG2, 1'b1, 0, 32'h22110000, 32'h00004433, 1'b0, ns, nb);
      chk("wrap_bus_cycles", 32'(nb), 32'd2);
`else
      run_op(OP_LH, 32'h1FF, REG2, 1'b1, 0, 32'h0, 32'h0, 1'b1, ns, nb);
      chk("nosplit_lh_bus", 32'(nb), 32'd0);
      chk("nosplit_lh_stall", 32'(ns), 32'd1);
      run_op(OP_SW, 32'h201, 32'h11223344, 1'b0, 0, 32'h0, 32'h0, 1'b1, ns, nb);
      chk("nosplit_sw_bus", 32'(nb), 32'd0);
`endif

      // Slave never acks: request lasts TIMEOUT_CYC cycles, then an abort.
      run_op(OP_LW, 32'h500, REG2, 1'b1, 1000, 32'h0, 32'h0, 1'b1, ns, nb);
      chk("timeout_bus_cycles", 32'(nb), 32'd4);
      chk("timeout_stall", 32'(ns), 32'd5);

      @(negedge clk);
      valid_i = 1'b1; aluop_i = OP_LW; mem_addr_i = 32'h600; wreg_i = 1'b1; wd_i = 5'd4;
      @(negedge clk);
      #1;
      chk("mid_beat0_req", 32'(bus_req_o), 32'h1);
      chk("mid_beat0_stall", 32'(stall_req_o), 32'h1);
      rst = 1'b0;
      #1;
      chk("mid_rst_req", 32'(bus_req_o), 32'h0);
      chk("mid_rst_stall", 32'(stall_req_o), 32'h0);
      chk("mid_rst_wreg", 32'(wreg_o), 32'h0);
      @(negedge clk);
      rst = 1'b1; aluop_i = OP_ADD; wdata_i = 32'hCAFEF00D; wd_i = 5'd9; wreg_i = 1'b1;
      #1;
      chk("post_rst_wdata", wdata_o, 32'hCAFEF00D);
      chk("post_rst_wreg", 32'(wreg_o), 32'h1);
      chk("post_rst_stall", 32'(stall_req_o), 32'h0);
      @(negedge clk);
      #1;
      chk("post_rst_no_req", 32'(bus_req_o), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_lsu.md
# mem_lsu

Multi-cycle load/store unit for the bittyCore MEM stage. It replaces the single-cycle combinational memory access with a registered bus master. The master uses a req/ack handshake, has a stall request to the pipeline control, and supports a wait-state timeout. Split handling for misaligned accesses is optional. Non-memory ops pass through with zero latency. Load/store ops stall the pipeline until the result is ready.

## Interface
- `ADDR_W`, 32: byte address width of `mem_addr_i` and `bus_addr_o`.
- `TIMEOUT_CYC`, 255: maximum number of ack-wait cycles per beat before abort. Legal range is 1..65535.
- `clk` in 1: clock. Everything is rising-edge.
- `rst` in 1: reset, asynchronous, active-low.
- `valid_i` in 1: EX/MEM register holds a live op.
- `aluop_i` in `AluOpBus`: operation. Memory ops are EXE_LB/LH/LW/LBU/LHU/SB/SH/SW.
- `wd_i` in `RegAddrBus`, `wreg_i` in 1, `wdata_i` in `RegBus`: writeback info from EX.
- `mem_addr_i` in ADDR_W: effective byte address.
- `reg2_i` in `RegBus`: store data.
- `wd_o` out `RegAddrBus`, `wreg_o` out 1, `wdata_o` out `RegBus`: stage result to MEM/WB.
- `stall_req_o` out 1: freeze the pipeline up to and including EX/MEM.
- `err_o` out 1: one-cycle pulse on timeout or misaligned abort.
- `bus_req_o` out 1, `bus_we_o` out 1, `bus_addr_o` out ADDR_W (word-aligned, bits[1:0]=0), `bus_sel_o` out 4, `bus_wdata_o` out 32: registered bus request.
- `bus_ack_i` in 1: the beat completes in the cycle where `bus_req_o` and `bus_ack_i` are both high.
- `bus_rdata_i` in 32: read data, valid while `bus_ack_i` is high on a read.

## Operation
- States: IDLE, BEAT0, BEAT1, DONE, ERR.
- IDLE, with a non-memory op or `valid_i`=0:
  - `wd_o`, `wreg_o` and `wdata_o` are driven combinationally from the inputs.
  - `stall_req_o`=0.
- IDLE, with a memory op and `valid_i`=1:
  - `stall_req_o`=1.
  - Capture the op, the offset k=`mem_addr_i[1:0]`, and the store data.
  - Next state is BEAT0.
- Beat split:
  - W with k≠0, or H with k=3, is a split access.
  - All other ops are single-beat.
  - H with k=1 is a single beat with sel 0110.
- BEAT0:
  - `bus_req_o`=1, `bus_addr_o`=addr&~3.
  - `bus_sel_o` = (byte mask << k) truncated to 4 bits. The byte mask is 0001 for B, 0011 for H, 1111 for W.
  - `bus_wdata_o` = store data replicated (B, H) or rotated left by 8k bits (W).
  - On ack: capture `bus_rdata_i` into beat0 register. Next state is BEAT1 if split, else DONE.
- BEAT1:
  - `bus_addr_o`=(addr&~3)+4, `bus_sel_o` = byte mask >> (4−k).
  - Wdata is the same rotated value.
  - On ack: capture into beat1 register. Next state is DONE.
- Load data: raw = {beat1,beat0} >> 8k, taking the low 32 bits. Extract byte/half/word, then sign- or zero-extend per op.
- DONE:
  - `stall_req_o`=0.
  - `wdata_o`=load result for loads, or `wdata_i` for stores.
  - `wd_o`/`wreg_o` from the captured values.
  - Next state is IDLE unconditionally. Upstream guarantees EX/MEM advances on this edge.
- Timeout:
  - The wait counter clears on entry to each beat and increments each cycle without ack.
  - When the counter reaches TIMEOUT_CYC, drop `bus_req_o` and go to ERR.
- ERR:
  - `err_o`=1, `wreg_o`=0, `stall_req_o`=0.
  - Next state is IDLE.
- Address wrap: a beat1 address at the top of the space wraps modulo 2^ADDR_W.

## Timing
- Reset value of every output is 0. The FSM resets to IDLE and the counter to 0.
- Reset mid-transaction aborts immediately: `bus_req_o` drops asynchronously and no writeback occurs.
- Single-beat access with zero wait states:
  - Stall is high in the op-arrival cycle and in BEAT0, so 2 stall cycles.
  - The result is presented in DONE, cycle 2.
  - The op advances at the DONE edge.
- Each wait state adds 1 cycle. A split adds at least 1 cycle.
- Bus request signals are held stable from request assertion until ack or abort.
- At most one beat is outstanding.
- `bus_ack_i` while `bus_req_o`=0 is ignored.

## Configuration
- `MISALIGN_SPLIT_EN` defined: split accesses are performed as described above.
- `MISALIGN_SPLIT_EN` undefined:
  - A split-class op goes IDLE→ERR directly, with no bus activity. `err_o` pulses and `wreg_o`=0.
  - The BEAT1 state and the beat1 register are not built.

## Test plan
- LW at 0x100, ack same cycle, rdata 0xDEADBEEF -> req with sel 1111 at 0x100; `wdata_o`=0xDEADBEEF in cycle 2; stall high for exactly 2 cycles.
- LB at 0x103, rdata 0x80123456 -> `wdata_o`=0xFFFFFF80. Same setup with LBU -> 0x00000080.
- SW 0x11223344 at 0x201 (split enabled), 1 wait state per beat -> beat0 at 0x200, sel 1110, wdata 0x22334411; beat1 at 0x204, sel 0001, same wdata; DONE after 4 bus cycles.
- LH at 0x1FF (k=3), beat0 rdata 0xAB000000, beat1 rdata 0x000000CD -> `wdata_o`=0xFFFFCDAB. With the macro undefined -> `err_o` pulse, no `bus_req_o`.
- TIMEOUT_CYC=4, ack never asserted -> req held for 4 cycles, then `err_o` pulses 1 cycle, `wreg_o`=0, stall drops.
- `rst` asserted low in BEAT0 -> `bus_req_o` and `stall_req_o` go to 0 immediately. After release, an ADD passthrough presents `wdata_i` the same cycle with no stall.
